hazard_stall_ctrl: RTL

- Central stall/flush controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards, squashes wrong-path instructions on EX-resolved redirects, and freezes the pipe while data memory is busy.
- Sequences an ecall/halt drain into a terminal HALTED state.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_stall_ctrl_if.sv | 44 ++++
 rtl/hazard_stall_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and the controller.
// The datapath side (master) supplies hazard information; the controller side
// (slave) returns the per-register stall/flush strobes and status.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard information from the pipeline registers
    logic [4:0]       IF_ID_Rs1;
    logic [4:0]       IF_ID_Rs2;
    logic             IF_ID_UseRs1;
    logic             IF_ID_UseRs2;
    logic             IF_ID_Halt;
    logic [4:0]       ID_EX_Rd;
    logic             ID_EX_MemRead;
    logic             EX_Redirect;
    logic             EX_MEM_MemReq;
    logic             DMem_Ready;

    // Pipeline control strobes and status
    logic             PC_Stall;
    logic             IF_ID_Stall;
    logic             IF_ID_Flush;
    logic             ID_EX_Stall;
    logic             ID_EX_Flush;
    logic             EX_MEM_Stall;
    logic             MEM_WB_Flush;
    logic             Halted;
    logic             Mem_Timeout;
    logic [CNT_W-1:0] Stall_Cnt;

    modport master (
        output IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs1, IF_ID_UseRs2, IF_ID_Halt,
               ID_EX_Rd, ID_EX_MemRead, EX_Redirect, EX_MEM_MemReq, DMem_Ready,
        input  PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
               EX_MEM_Stall, MEM_WB_Flush, Halted, Mem_Timeout, Stall_Cnt
    );

    modport slave (
        input  IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs1, IF_ID_UseRs2, IF_ID_Halt,
               ID_EX_Rd, ID_EX_MemRead, EX_Redirect, EX_MEM_MemReq, DMem_Ready,
        output PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
               EX_MEM_Stall, MEM_WB_Flush, Halted, Mem_Timeout, Stall_Cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for a 5-stage pipeline: load-use bubbles,
// EX redirect squash, DMem-busy freeze, halt drain, stall counter and a
// sticky DMem timeout flag. Strobes are combinational from state and inputs.
module hazard_stall_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  bus
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           state;
    logic [DW-1:0]    drain_cnt;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_timeout;

    logic mem_wait;
    logic load_use;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, mem_wb_flush;

    assign mem_wait = bus.EX_MEM_MemReq & ~bus.DMem_Ready;
    assign load_use = bus.ID_EX_MemRead & (bus.ID_EX_Rd != 5'd0) &
                      ((bus.IF_ID_UseRs1 & (bus.IF_ID_Rs1 == bus.ID_EX_Rd)) |
                       (bus.IF_ID_UseRs2 & (bus.IF_ID_Rs2 == bus.ID_EX_Rd)));

    // Same-cycle stall/flush strobes from current state and hazard inputs
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    // EX is frozen, so a pending redirect is simply re-presented later
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end else if (bus.EX_Redirect) begin
                    // Younger load_use / halt in IF/ID are wrong-path and die here
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (bus.IF_ID_Halt) begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_wait) begin
                    // A DMem wait freezes the whole drain exactly like a RUN freeze
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end else begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                end
            end
            HALTED: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM, drain/wait counters, stall counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;

            if (!mem_wait)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(MEM_TIMEOUT))
                wait_cnt <= wait_cnt + 1'b1;

            // Set on the wait cycle that brings wait_cnt to MEM_TIMEOUT
            if (mem_wait && (wait_cnt >= WW'(MEM_TIMEOUT - 1)))
                mem_timeout <= 1'b1;

            unique case (state)
                RUN: begin
                    if (!mem_wait && !bus.EX_Redirect && !load_use && bus.IF_ID_Halt) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (!mem_wait) begin
                        if (drain_cnt == DW'(DRAIN_CYCLES - 1))
                            state <= HALTED;
                        else
                            drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.PC_Stall     = pc_stall;
    assign bus.IF_ID_Stall  = if_id_stall;
    assign bus.IF_ID_Flush  = if_id_flush;
    assign bus.ID_EX_Stall  = id_ex_stall;
    assign bus.ID_EX_Flush  = id_ex_flush;
    assign bus.EX_MEM_Stall = ex_mem_stall;
    assign bus.MEM_WB_Flush = mem_wb_flush;
    assign bus.Halted       = (state == HALTED);
    assign bus.Mem_Timeout  = mem_timeout;
    assign bus.Stall_Cnt    = stall_cnt;
endmodule
